// File: rtl/cla_pkg.sv
// Shared definitions for the 5-bit carry-lookahead adder/subtractor family.
package cla_pkg;

    // Default operand/result width for the adder and subtractor datapaths.
    localparam int CLA_WIDTH = 5;

    // Status flags produced alongside every arithmetic result.
    typedef struct packed {
        logic bout;
        logic ovf;
        logic zero;
    } cla_flags_t;

    // Result bundle {Diff, Bout, Ovf, Zero} at the default width; the adder's
    // output stage registers the same layout.
    typedef struct packed {
        logic [CLA_WIDTH-1:0] diff;
        cla_flags_t           flags;
    } cla_result_t;

endpackage

// File: rtl/cla_core.sv
// Purely combinational WIDTH-bit carry-lookahead adder: sum = a + b + cin.
// Every carry is a flat sum-of-products of generate/propagate terms, so no
// carry depends on a previously computed carry.
module cla_core
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   gen_ext;
    logic [WIDTH:0]   c;

    // Carry into bit i+1: OR over j of gen_ext[j] & p[j] & ... & p[i], where
    // gen_ext[0] is the carry-in and gen_ext[j] = g[j-1].
    function automatic logic lookahead(input logic [WIDTH:0] gen,
                                       input logic [WIDTH-1:0] prop,
                                       input int i);
        logic r;
        logic prod;
        r = 1'b0;
        for (int j = 0; j <= WIDTH; j++) begin
            if (j <= i + 1) begin
                prod = gen[j];
                for (int k = 0; k < WIDTH; k++) begin
                    if (k >= j && k <= i) begin
                        prod = prod & prop[k];
                    end
                end
                r = r | prod;
            end
        end
        return r;
    endfunction

    assign g       = a & b;
    assign p       = a ^ b;
    assign gen_ext = {g, cin};
    assign c[0]    = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign c[i+1] = lookahead(gen_ext, p, i);
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/cla_sub_pipe_5bit.sv
// Two-stage pipelined subtractor Diff = A - B - Bin, computed as
// A + ~B + ~Bin on a lookahead core, with valid/ready on both sides.
module cla_sub_pipe_5bit
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    logic             s1_en;
    logic             s2_en;
    logic             s1_valid;
    logic             s2_valid;

    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] bn_p1;
    logic             cin_p1;
    logic             asgn_p1;
    logic             bsgn_p1;

    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    cla_flags_t       flags_nxt;

    logic [WIDTH-1:0] diff_p2;
    cla_flags_t       flags_p2;

    // A stage advances when it is empty or its contents move downstream.
    always_comb begin
        s2_en    = !s2_valid || out_ready;
        s1_en    = !s1_valid || s2_en;
        in_ready = s1_en;
    end

    // ---- stage 1: capture minuend, inverted subtrahend, inverted borrow ----
    // Inverting B and Bin here turns the subtraction into a plain addition.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            a_p1     <= '0;
            bn_p1    <= '0;
            cin_p1   <= 1'b0;
            asgn_p1  <= 1'b0;
            bsgn_p1  <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            a_p1     <= A;
            bn_p1    <= ~B;
            cin_p1   <= ~Bin;
            asgn_p1  <= A[WIDTH-1];
            bsgn_p1  <= B[WIDTH-1];
        end
    end

    cla_core #(.WIDTH(WIDTH)) u_core (
        .a    (a_p1),
        .b    (bn_p1),
        .cin  (cin_p1),
        .sum  (sum_p1),
        .cout (cout_p1)
    );

    // Flags: a missing carry-out means the unsigned subtraction borrowed;
    // signed overflow only when operand signs differ and the result sign
    // departs from the minuend's.
    always_comb begin
        flags_nxt      = '0;
        flags_nxt.bout = ~cout_p1;
        flags_nxt.ovf  = (asgn_p1 != bsgn_p1) && (sum_p1[WIDTH-1] != asgn_p1);
        flags_nxt.zero = (sum_p1 == '0);
    end

    // ---- stage 2: register difference and flags for the output side ----
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            diff_p2  <= '0;
            flags_p2 <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            diff_p2  <= sum_p1;
            flags_p2 <= flags_nxt;
        end
    end

    assign out_valid = s2_valid;
    assign Diff      = diff_p2;
    assign Bout      = flags_p2.bout;
    assign Ovf       = flags_p2.ovf;
    assign Zero      = flags_p2.zero;

endmodule
